truth_table_sweeper: RTL

- Sequential stimulus/capture stage placed directly upstream of an N_IN-input, single-output combinational benchmark function (inputs x0..x{N_IN-1}, output y0).
- Drives every minterm 0..2^N_IN-1 onto the function inputs and samples the output.
- Packs the samples into WORD_W-bit truth-table words and streams them out over a valid/ready handshake.
- Counts the on-set size, so the benchmark netlists can be characterised in simulation and on FPGA.

---
 rtl/tts_pkg.sv | 37 +++
 rtl/tts_lat_pipe.sv | 38 +++
 rtl/truth_table_sweeper.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tts_pkg.sv
// ============================================================================
//  tts_pkg : shared types and geometry helpers for truth_table_sweeper
//  Rev 1.0
// ============================================================================
`default_nettype none

package tts_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_FIN   = 3'd4
  } tts_state_t;

  localparam int N_IN_DEF   = 8;
  localparam int WORD_W_DEF = 32;
  localparam int N_MIN      = 2 ** N_IN_DEF;
  localparam int N_WORDS    = N_MIN / WORD_W_DEF;
  localparam int CNT_W      = N_IN_DEF + 1;

  function automatic int tts_n_min(input int n_in);
    return 1 << n_in;
  endfunction

  // Word width must be a power of two that tiles the minterm space exactly.
  function automatic bit tts_geom_ok(input int n_in, input int word_w);
    int n_min;
    n_min = 1 << n_in;
    return (word_w >= 1) && (word_w <= n_min) &&
           ((word_w & (word_w - 1)) == 0) && ((n_min % word_w) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tts_lat_pipe.sv
// ============================================================================
//  tts_lat_pipe : LAT-deep tag pipe keeping sample tags aligned with y_in
//  Rev 1.0
// ============================================================================
`default_nettype none

module tts_lat_pipe #(
  parameter int LAT = 0,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_d
);

  generate
    if (LAT == 0) begin : g_wire
      logic w_unused;
      assign w_unused = clk ^ rst_n;
      assign o_d      = i_d;
    end else begin : g_sr
      logic [W-1:0] r_sr [LAT];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT; i++) r_sr[i] <= '0;
        end else begin
          r_sr[0] <= i_d;
          for (int i = 1; i < LAT; i++) r_sr[i] <= r_sr[i-1];
        end
      end
      assign o_d = r_sr[LAT-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
//  truth_table_sweeper : sweeps all minterms of an N_IN-input function and
//  streams the captured truth table as WORD_W-bit words with on-set count.
//  Rev 1.0
// ============================================================================
`default_nettype none

module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int WORD_W = 32,
  parameter int LAT    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   x_out,
  input  logic              y_in,
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     onset_cnt,
  output logic              tt_valid,
  input  logic              tt_ready,
  output logic [WORD_W-1:0] tt_data,
  output logic [N_IN-1:0]   tt_idx,
  output logic              tt_last
);

  localparam int TT_MIN = tts_n_min(N_IN);
  localparam int TT_CW  = N_IN + 1;
  localparam int WB     = $clog2(WORD_W);
  localparam int BI_W   = (WB > 0) ? WB : 1;
  localparam int DW     = (LAT > 0) ? $clog2(LAT + 1) : 1;

  generate
    if (!tts_geom_ok(N_IN, WORD_W)) begin : g_bad_geom
      $error("truth_table_sweeper: WORD_W must be a power of two dividing 2**N_IN");
    end
  endgenerate

  tts_state_t r_state, w_state_nxt;

  logic [TT_CW-1:0]  r_min;
  logic [N_IN-1:0]   r_widx;
  logic [WORD_W-1:0] r_buf;
  logic [TT_CW-1:0]  r_onset;
  logic [DW-1:0]     r_drn;
  logic [BI_W-1:0]   w_bit;
  logic              w_last_issue, w_drain_done, w_last_word;
  logic              w_cap_vld;
  logic [BI_W-1:0]   w_cap_bit;

  generate
    if (WB > 0) begin : g_bit
      assign w_bit = r_min[BI_W-1:0];
    end else begin : g_bit0
      assign w_bit = '0;
    end
  endgenerate

  assign w_last_issue = (w_bit == BI_W'(WORD_W - 1));
  assign w_drain_done = (r_drn == DW'((LAT > 0) ? LAT - 1 : 0));
  // The counter has already stepped past the word, so the end is 2**N_IN itself.
  assign w_last_word  = (r_min == TT_CW'(TT_MIN));

  tts_lat_pipe #(.LAT(LAT), .W(BI_W + 1)) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({(r_state == ST_ISSUE), w_bit}),
    .o_d   ({w_cap_vld, w_cap_bit})
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_last_issue) w_state_nxt = (LAT > 0) ? ST_DRAIN : ST_EMIT;
      ST_DRAIN: if (w_drain_done) w_state_nxt = ST_EMIT;
      ST_EMIT:  if (tt_ready) w_state_nxt = w_last_word ? ST_FIN : ST_ISSUE;
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state == ST_ISSUE) || (r_state == ST_DRAIN) || (r_state == ST_EMIT);
    done     = (r_state == ST_FIN);
    tt_valid = (r_state == ST_EMIT);
    tt_last  = (r_state == ST_EMIT) && w_last_word;
    x_out    = (r_state == ST_ISSUE) ? r_min[N_IN-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_min   <= '0;
      r_widx  <= '0;
      r_buf   <= '0;
      r_onset <= '0;
      r_drn   <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_min   <= '0;
        r_widx  <= '0;
        r_buf   <= '0;
        r_onset <= '0;
      end
      if (r_state == ST_ISSUE) r_min <= r_min + 1'b1;
      if (r_state == ST_ISSUE)      r_drn <= '0;
      else if (r_state == ST_DRAIN) r_drn <= r_drn + 1'b1;
      if (w_cap_vld && (r_state == ST_ISSUE || r_state == ST_DRAIN)) begin
        r_buf[w_cap_bit] <= y_in;
        r_onset          <= r_onset + {{(TT_CW-1){1'b0}}, y_in};
      end
      if (r_state == ST_EMIT && tt_ready && !w_last_word) r_widx <= r_widx + 1'b1;
    end
  end

  assign onset_cnt = r_onset;
  assign tt_data   = r_buf;
  assign tt_idx    = r_widx;

endmodule

`default_nettype wire
